// File: rtl/fft_spectrum_sink.sv
// rtl/fft_spectrum_sink.sv - FFT magnitude frame sink with spectrum buffer, peak search and frame checks
module fft_spectrum_sink #(
  parameter int FFT_N  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_valid,
  input  logic [31:0]       in_modulus,
  input  logic              clear_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              frame_done,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [31:0]       peak_value,
  output logic [15:0]       frame_cnt,
  output logic              err_len,
  output logic              err_sop
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_N - 1);
  localparam bit                ONE_BIN  = (FFT_N == 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [ADDR_W-1:0] run_bin_q, run_bin_d;
  logic [31:0]       run_val_q, run_val_d;
  logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
  logic [31:0]       peak_value_q, peak_value_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              err_len_q, err_len_d;
  logic              err_sop_q, err_sop_d;
  logic [31:0]       rd_data_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              publish, abort_len;
  logic [ADDR_W-1:0] fin_bin;
  logic [31:0]       fin_val;

  // Contents are never reset so the array maps onto block RAM.
  logic [31:0] buf_mem [0:(2**ADDR_W)-1];

  always_ff @(posedge sys_clk) begin
    if (wr_en) buf_mem[wr_addr] <= in_modulus;
  end

  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    run_bin_d    = run_bin_q;
    run_val_d    = run_val_q;
    peak_bin_d   = peak_bin_q;
    peak_value_d = peak_value_q;
    frame_cnt_d  = frame_cnt_q;
    err_len_d    = err_len_q & ~clear_err;
    err_sop_d    = err_sop_q & ~clear_err;
    wr_en        = 1'b0;
    wr_addr      = bin_cnt_q;
    publish      = 1'b0;
    abort_len    = 1'b0;
    fin_bin      = run_bin_q;
    fin_val      = run_val_q;

    if (state_q == DONE) state_d = IDLE;

    if (in_valid) begin
      if (in_sop) begin
        // A sop always restarts at bin 0, whatever frame was in flight.
        wr_en     = 1'b1;
        wr_addr   = '0;
        bin_cnt_d = ADDR_W'(1);
        run_bin_d = '0;
        run_val_d = in_modulus;
        fin_bin   = '0;
        fin_val   = in_modulus;
        if (state_q == COLLECT) err_sop_d = 1'b1;
        if (in_eop) begin
          if (ONE_BIN) publish = 1'b1;
          else         abort_len = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end else if (state_q == COLLECT) begin
        wr_en     = 1'b1;
        wr_addr   = bin_cnt_q;
        bin_cnt_d = bin_cnt_q + ADDR_W'(1);
        if (in_modulus > run_val_q) begin
          fin_bin = bin_cnt_q;
          fin_val = in_modulus;
        end
        run_bin_d = fin_bin;
        run_val_d = fin_val;
        if (bin_cnt_q == LAST_BIN) begin
          if (in_eop) publish = 1'b1;
          else        abort_len = 1'b1;
        end else if (in_eop) begin
          abort_len = 1'b1;
        end
      end
    end

    if (publish) begin
      state_d      = DONE;
      bin_cnt_d    = '0;
      peak_bin_d   = fin_bin;
      peak_value_d = fin_val;
      frame_cnt_d  = frame_cnt_q + 16'd1;
    end
    if (abort_len) begin
      state_d   = IDLE;
      bin_cnt_d = '0;
      err_len_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bin_cnt_q    <= '0;
      run_bin_q    <= '0;
      run_val_q    <= '0;
      peak_bin_q   <= '0;
      peak_value_q <= '0;
      frame_cnt_q  <= '0;
      err_len_q    <= 1'b0;
      err_sop_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      run_bin_q    <= run_bin_d;
      run_val_q    <= run_val_d;
      peak_bin_q   <= peak_bin_d;
      peak_value_q <= peak_value_d;
      frame_cnt_q  <= frame_cnt_d;
      err_len_q    <= err_len_d;
      err_sop_q    <= err_sop_d;
      rd_data_q    <= buf_mem[rd_addr];
    end
  end

  assign frame_done = (state_q == DONE);
  assign peak_bin   = peak_bin_q;
  assign peak_value = peak_value_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_len    = err_len_q;
  assign err_sop    = err_sop_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_fft_spectrum_sink.sv
// tb/tb_fft_spectrum_sink.sv - directed bench for fft_spectrum_sink (1024-bin and 1-bin instances)
module tb_fft_spectrum_sink;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst_n, in_sop, in_eop, in_valid, clear_err;
  logic [31:0] in_modulus, rd_data, peak_value;
  logic [9:0]  rd_addr, peak_bin;
  logic        frame_done, err_len, err_sop;
  logic [15:0] frame_cnt;

  logic        in_sop1, in_eop1, in_valid1, clear_err1;
  logic [31:0] in_modulus1, rd_data1, peak_value1;
  logic [0:0]  rd_addr1, peak_bin1;
  logic        frame_done1, err_len1, err_sop1;
  logic [15:0] frame_cnt1;

  fft_spectrum_sink dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_sop(in_sop), .in_eop(in_eop),
    .in_valid(in_valid), .in_modulus(in_modulus), .clear_err(clear_err),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done),
    .peak_bin(peak_bin), .peak_value(peak_value), .frame_cnt(frame_cnt),
    .err_len(err_len), .err_sop(err_sop)
  );

  fft_spectrum_sink #(.FFT_N(1), .ADDR_W(1)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_sop(in_sop1), .in_eop(in_eop1),
    .in_valid(in_valid1), .in_modulus(in_modulus1), .clear_err(clear_err1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .frame_done(frame_done1),
    .peak_bin(peak_bin1), .peak_value(peak_value1), .frame_cnt(frame_cnt1),
    .err_len(err_len1), .err_sop(err_sop1)
  );

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int done_bins[$];
  logic [31:0] vec [0:1023];

  always @(negedge sys_clk) begin
    if (frame_done === 1'b1) begin
      done_count++;
      done_bins.push_back(int'(peak_bin));
    end
  end

  task automatic beat(input bit s, input bit e, input logic [31:0] m);
    @(negedge sys_clk);
    in_valid = 1'b1; in_sop = s; in_eop = e; in_modulus = m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    end
  endtask

  task automatic send(input int n, input bit with_sop, input bit with_eop);
    for (int i = 0; i < n; i++) beat(with_sop && i == 0, with_eop && i == n - 1, vec[i]);
  endtask

  task automatic ramp();
    for (int i = 0; i < 1024; i++) vec[i] = i;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    int d0;
    rst_n = 1'b0;
    idle(3);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_peak_bin", 32'(peak_bin), 32'd0);
    chk("rst_peak_value", peak_value, 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_err_sop", 32'(err_sop), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    d0 = done_count;
    beat(1'b0, 1'b0, 32'd5);
    beat(1'b0, 1'b1, 32'd6);
    idle(3);
    chk("nosop_err_len", 32'(err_len), 32'd0);
    chk("nosop_done", 32'(done_count - d0), 32'd0);
  endtask

  task automatic test_ramp();
    int d0;
    ramp();
    d0 = done_count;
    send(1024, 1'b1, 1'b1);
    chk("ramp_not_early", 32'(frame_done), 32'd0);
    idle(1);
    chk("ramp_done", 32'(frame_done), 32'd1);
    chk("ramp_peak_bin", 32'(peak_bin), 32'd1023);
    chk("ramp_peak_value", peak_value, 32'd1023);
    chk("ramp_frame_cnt", 32'(frame_cnt), 32'd1);
    rd_addr = 10'd5;
    idle(1);
    chk("ramp_done_one_cycle", 32'(frame_done), 32'd0);
    chk("ramp_rd5", rd_data, 32'd5);
    rd_addr = 10'd1023;
    idle(1);
    chk("ramp_rd1023", rd_data, 32'd1023);
    idle(2);
    chk("ramp_done_count", 32'(done_count - d0), 32'd1);
  endtask

  task automatic test_tie();
    for (int i = 0; i < 1024; i++) vec[i] = 32'd7;
    vec[100] = 32'hFFFF_FFFF;
    vec[200] = 32'hFFFF_FFFF;
    send(1024, 1'b1, 1'b1);
    idle(1);
    chk("tie_done", 32'(frame_done), 32'd1);
    chk("tie_peak_bin", 32'(peak_bin), 32'd100);
    chk("tie_peak_value", peak_value, 32'hFFFF_FFFF);
    chk("tie_frame_cnt", 32'(frame_cnt), 32'd2);
    idle(2);
  endtask

  task automatic test_short();
    int d0;
    ramp();
    d0 = done_count;
    send(960, 1'b1, 1'b1);
    idle(3);
    chk("short_err_len", 32'(err_len), 32'd1);
    chk("short_done", 32'(done_count - d0), 32'd0);
    chk("short_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("short_peak_hold", 32'(peak_bin), 32'd100);
    @(negedge sys_clk);
    clear_err = 1'b1;
    @(negedge sys_clk);
    clear_err = 1'b0;
    chk("short_cleared", 32'(err_len), 32'd0);
  endtask

  task automatic test_overflow();
    int d0;
    ramp();
    d0 = done_count;
    send(1023, 1'b1, 1'b0);
    beat(1'b0, 1'b0, vec[1023]);
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    chk("ovf_set_wins", 32'(err_len), 32'd1);
    idle(3);
    chk("ovf_done", 32'(done_count - d0), 32'd0);
    chk("ovf_frame_cnt", 32'(frame_cnt), 32'd2);
    @(negedge sys_clk);
    clear_err = 1'b1;
    @(negedge sys_clk);
    clear_err = 1'b0;
    chk("ovf_cleared", 32'(err_len), 32'd0);
  endtask

  task automatic test_sop_mid();
    int d0;
    for (int i = 0; i < 1024; i++) vec[i] = 32'd50000;
    d0 = done_count;
    send(500, 1'b1, 1'b0);
    ramp();
    vec[10] = 32'd3000;
    send(1024, 1'b1, 1'b1);
    idle(3);
    chk("sopmid_err_sop", 32'(err_sop), 32'd1);
    chk("sopmid_err_len", 32'(err_len), 32'd0);
    chk("sopmid_done", 32'(done_count - d0), 32'd1);
    chk("sopmid_peak_bin", 32'(peak_bin), 32'd10);
    chk("sopmid_peak_value", peak_value, 32'd3000);
    chk("sopmid_frame_cnt", 32'(frame_cnt), 32'd3);
  endtask

  task automatic test_back_to_back();
    int d0, n0;
    d0 = done_count;
    n0 = done_bins.size();
    ramp();
    send(1024, 1'b1, 1'b1);
    for (int i = 0; i < 1024; i++) vec[i] = 32'd9;
    vec[3] = 32'd77;
    send(1024, 1'b1, 1'b1);
    idle(3);
    chk("b2b_done", 32'(done_count - d0), 32'd2);
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'd5);
    if (done_bins.size() >= n0 + 2) begin
      chk("b2b_first_peak", 32'(done_bins[n0]), 32'd1023);
      chk("b2b_second_peak", 32'(done_bins[n0 + 1]), 32'd3);
    end
    chk("b2b_peak_value", peak_value, 32'd77);
  endtask

  task automatic test_reset_mid();
    int d0;
    ramp();
    send(300, 1'b1, 1'b0);
    @(negedge sys_clk);
    rst_n = 1'b0;
    idle(2);
    chk("rmid_frame_done", 32'(frame_done), 32'd0);
    chk("rmid_peak_bin", 32'(peak_bin), 32'd0);
    chk("rmid_peak_value", peak_value, 32'd0);
    chk("rmid_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rmid_err_sop", 32'(err_sop), 32'd0);
    chk("rmid_rd_data", rd_data, 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    d0 = done_count;
    for (int i = 300; i < 1024; i++) beat(1'b0, i == 1023, vec[i]);
    idle(3);
    chk("rmid_no_done", 32'(done_count - d0), 32'd0);
    chk("rmid_err_len", 32'(err_len), 32'd0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 65535; i++) begin
      @(negedge sys_clk);
      in_valid1 = 1'b1; in_sop1 = 1'b1; in_eop1 = 1'b1; in_modulus1 = i;
    end
    @(negedge sys_clk);
    in_valid1 = 1'b0;
    chk("wrap_ffff", 32'(frame_cnt1), 32'h0000_FFFF);
    chk("wrap_peak_value", peak_value1, 32'd65534);
    @(negedge sys_clk);
    in_valid1 = 1'b1; in_modulus1 = 32'd1;
    @(negedge sys_clk);
    in_valid1 = 1'b0;
    chk("wrap_zero", 32'(frame_cnt1), 32'd0);
    chk("wrap_done", 32'(frame_done1), 32'd1);
    chk("wrap_err_len", 32'(err_len1), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b0; clear_err = 1'b0;
    in_modulus = '0; rd_addr = '0;
    in_sop1 = 1'b0; in_eop1 = 1'b0; in_valid1 = 1'b0; clear_err1 = 1'b0;
    in_modulus1 = '0; rd_addr1 = '0;
    test_reset();
    test_ramp();
    test_tie();
    test_short();
    test_overflow();
    test_sop_mid();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_spectrum_sink.md
FFT_SPECTRUM_SINK -- requirements
Module: fft_spectrum_sink

Interface
REQ-001 The module SHALL have parameter FFT_N, default 1024, giving the number of bins per spectrum frame.
REQ-002 The module SHALL have parameter ADDR_W, default 10, giving the bin index width, with 2**ADDR_W >= FFT_N.
REQ-003 sys_clk  input  1  Single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous, active-low.
REQ-005 in_sop  input  1  Start of frame; SHALL be qualified by in_valid.
REQ-006 in_eop  input  1  End of frame; SHALL be qualified by in_valid.
REQ-007 in_valid  input  1  Beat qualifier for the FFT magnitude stream.
REQ-008 in_modulus  input  32  Unsigned bin magnitude.
REQ-009 clear_err  input  1  Synchronous clear of the sticky error flags.
REQ-010 rd_addr  input  ADDR_W  Spectrum buffer read address.
REQ-011 rd_data  output  32  Registered buffer read data.
REQ-012 frame_done  output  1  One-cycle pulse marking a valid frame.
REQ-013 peak_bin  output  ADDR_W  Index of the maximum bin of the last valid frame.
REQ-014 peak_value  output  32  Magnitude at peak_bin.
REQ-015 frame_cnt  output  16  Count of valid frames.
REQ-016 err_len  output  1  Sticky flag for a frame-length error.
REQ-017 err_sop  output  1  Sticky flag for an unexpected sop.

Function
REQ-018 The FSM SHALL have the states IDLE, COLLECT and DONE, and SHALL reset to IDLE.
REQ-019 A beat SHALL be a cycle with in_valid=1; in_sop and in_eop SHALL be ignored when in_valid=0.
REQ-020 In IDLE, a beat without sop SHALL be discarded; a beat with sop SHALL write bin 0, set the running peak to (0, in_modulus), set bin_cnt=1, and go to COLLECT.
REQ-021 In COLLECT, each beat without sop SHALL write in_modulus to buffer[bin_cnt] and then increment bin_cnt.
REQ-022 The running peak SHALL update only when in_modulus > peak, by strict unsigned compare; on a tie the lower bin SHALL be kept.
REQ-023 In COLLECT, a beat with sop SHALL set err_sop, discard the partial frame, and restart as in REQ-020 in the same cycle.
REQ-024 On an eop beat that makes the received count exactly FFT_N, the FSM SHALL go to DONE.
REQ-025 On an eop beat with count != FFT_N, the block SHALL set err_len and return to IDLE without publishing.
REQ-026 A non-eop beat at bin_cnt = FFT_N-1 (overflow) SHALL set err_len and return to IDLE with nothing published.
REQ-027 A sop and eop on the same beat in IDLE SHALL be a 1-bin frame, publishable only if FFT_N=1; otherwise it SHALL set err_len.
REQ-028 DONE SHALL last exactly one cycle, in which frame_done=1, peak_bin/peak_value take the running peak, and frame_cnt increments with wrap from 0xFFFF to 0.
REQ-029 In DONE, a sop beat SHALL start a new frame as in REQ-020; other beats SHALL be discarded; the next state SHALL be COLLECT or IDLE accordingly.
REQ-030 Latency from the eop beat to frame_done SHALL be 1 cycle.
REQ-031 peak_bin and peak_value SHALL hold their value until the next frame_done.
REQ-032 rd_data SHALL equal buffer[rd_addr] sampled one cycle earlier.
REQ-033 The buffer SHALL be single-port-write and overwritten in place; reads during COLLECT MAY return mixed-frame data.
REQ-034 clear_err=1 SHALL clear err_len/err_sop; when clear_err coincides with an error event, the flag SHALL be set (set wins).
REQ-035 The buffer SHALL be inferable as block RAM with no reset on its contents.

Reset
REQ-036 While rst_n=0, the block SHALL hold: state IDLE, bin_cnt 0, frame_done 0, peak_bin 0, peak_value 0, frame_cnt 0, err_len 0, err_sop 0, rd_data 0.
REQ-037 Reset asserted mid-frame SHALL abandon the frame, with no frame_done after release.
REQ-038 The first frame after release SHALL require a sop.

Verification
REQ-039 Ramp frame: 1024 beats with modulus=k at bin k, sop on beat 0, eop on beat 1023 -> frame_done 1 cycle after eop, peak_bin=1023, peak_value=1023, frame_cnt=1, rd_addr=5 gives rd_data=5 next cycle.
REQ-040 Tie frame: all bins 7 except bins 100 and 200 = 0xFFFF_FFFF -> peak_bin=100, peak_value=0xFFFF_FFFF.
REQ-041 Short frame: eop on beat 959 -> err_len=1, no frame_done, frame_cnt unchanged; then clear_err -> err_len=0 next cycle.
REQ-042 sop at beat 500 mid-frame, then a full 1024-beat frame -> err_sop=1, exactly one frame_done, peak taken from the second frame only.
REQ-043 Back-to-back: the next sop beat falls in the DONE cycle -> both frames are published and frame_cnt increments by 2; frame_cnt preset to 0xFFFF by running 65535 frames wraps to 0.
REQ-044 rst_n pulsed low at beat 300 -> all outputs return to their reset values and no frame_done follows.
